// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding and
// the write-enable pattern for a full 32-bit word.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_t;

  localparam logic [3:0] W_EN_WORD = 4'hF;

endpackage

// File: rtl/imem_boot_loader_word_packer.sv
// Packs a byte stream little-endian into 32-bit words. The packed word output
// already contains the byte being strobed in, so the caller can capture it on
// the same edge that completes the word.
module imem_boot_loader_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  byte_cnt_reg;
  logic [31:0] word_reg;

  // Lane gi takes the incoming byte when it is the lane currently addressed.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign word[gi*8 +: 8] = (byte_en && (byte_cnt_reg == 2'(gi)))
                               ? byte_in : word_reg[gi*8 +: 8];
    end
  endgenerate

  assign word_full = byte_en && (byte_cnt_reg == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_reg <= 2'd0;
      word_reg     <= 32'd0;
    end else if (clear) begin
      byte_cnt_reg <= 2'd0;
      word_reg     <= 32'd0;
    end else if (byte_en) begin
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
      word_reg     <= word;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it word by word
// into the instruction SRAM and holds the core in reset until it is complete.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        reload,
  output logic [3:0]  im_w_en,
  output logic [15:0] im_address,
  output logic [31:0] im_write_data,
  output logic        cpu_rst,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_reg;
  logic [15:0] hdr_reg;
  logic [15:0] word_cnt_reg;
  logic [3:0]  im_w_en_reg;
  logic [15:0] im_address_reg;
  logic [31:0] im_write_data_reg;
  logic        cpu_rst_reg;
  logic        load_done_reg;
  logic        load_err_reg;

  logic        xfer;
  logic        pack_en;
  logic        pack_clear;
  logic [31:0] packed_word;
  logic        word_full;
  logic [15:0] hdr_word;

  // Ready is a pure decode of the state so it never depends on byte_valid.
  assign byte_ready = (state_reg == ST_HDR0) || (state_reg == ST_HDR1) ||
                      (state_reg == ST_DATA);
  assign xfer       = byte_valid && byte_ready;
  assign pack_en    = xfer && (state_reg == ST_DATA);
  assign pack_clear = (state_reg == ST_DONE) && reload;
  assign hdr_word   = {byte_data, hdr_reg[7:0]};

  imem_boot_loader_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pack_clear),
    .byte_en   (pack_en),
    .byte_in   (byte_data),
    .word      (packed_word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_HDR0;
      hdr_reg           <= 16'd0;
      word_cnt_reg      <= 16'd0;
      im_w_en_reg       <= 4'd0;
      im_address_reg    <= BASE_ADDR;
      im_write_data_reg <= 32'd0;
      cpu_rst_reg       <= 1'b1;
      load_done_reg     <= 1'b0;
      load_err_reg      <= 1'b0;
    end else begin
      im_w_en_reg <= 4'd0;
      case (state_reg)
        ST_HDR0: begin
          if (xfer) begin
            hdr_reg[7:0] <= byte_data;
            state_reg    <= ST_HDR1;
          end
        end
        ST_HDR1: begin
          if (xfer) begin
            hdr_reg[15:8] <= byte_data;
            if (hdr_word == 16'd0) begin
              state_reg     <= ST_DONE;
              cpu_rst_reg   <= 1'b0;
              load_done_reg <= 1'b1;
            end else if ({1'b0, hdr_word} > MAX_W) begin
              state_reg    <= ST_ERR;
              load_err_reg <= 1'b1;
            end else begin
              state_reg <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          // The fourth byte completes the word; the SRAM write is issued next cycle.
          if (word_full) begin
            state_reg         <= ST_WRITE;
            im_w_en_reg       <= W_EN_WORD;
            im_address_reg    <= BASE_ADDR + (word_cnt_reg << 2);
            im_write_data_reg <= packed_word;
          end
        end
        ST_WRITE: begin
          word_cnt_reg <= word_cnt_reg + 16'd1;
          if (word_cnt_reg == hdr_reg - 16'd1) begin
            state_reg     <= ST_DONE;
            cpu_rst_reg   <= 1'b0;
            load_done_reg <= 1'b1;
          end else begin
            state_reg <= ST_DATA;
          end
        end
        ST_DONE: begin
          if (reload) begin
            state_reg     <= ST_HDR0;
            hdr_reg       <= 16'd0;
            word_cnt_reg  <= 16'd0;
            cpu_rst_reg   <= 1'b1;
            load_done_reg <= 1'b0;
          end
        end
        ST_ERR: begin
          state_reg <= ST_ERR;
        end
        default: begin
          state_reg <= ST_HDR0;
        end
      endcase
    end
  end

  assign im_w_en       = im_w_en_reg;
  assign im_address    = im_address_reg;
  assign im_write_data = im_write_data_reg;
  assign cpu_rst       = cpu_rst_reg;
  assign load_done     = load_done_reg;
  assign load_err      = load_err_reg;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: drives byte streams and checks SRAM
// writes, core-reset release, error handling, mid-load reset and reload.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        reload;
  logic [3:0]  im_w_en;
  logic [15:0] im_address;
  logic [31:0] im_write_data;
  logic        cpu_rst;
  logic        load_done;
  logic        load_err;

  int total_cnt = 0;
  int fail_cnt  = 0;
  int cyc       = 0;
  int wr_cnt    = 0;
  logic [31:0] mem [int];

  imem_boot_loader dut (
    .clk           (clk),
    .rst           (rst),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .reload        (reload),
    .im_w_en       (im_w_en),
    .im_address    (im_address),
    .im_write_data (im_write_data),
    .cpu_rst       (cpu_rst),
    .load_done     (load_done),
    .load_err      (load_err)
  );

  always #5 clk = ~clk;

  // SRAM model: captures every write pulse the loader issues.
  always @(posedge clk) begin
    cyc++;
    if (im_w_en != 4'h0) begin
      mem[int'(im_address)] = im_write_data;
      wr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) check("ready_wait", {31'd0, byte_ready}, 32'd1);
    tick();
    byte_valid = 1'b0;
    $display("byte %02h accepted at cycle %0d", b, cyc);
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) tick();
    send_byte(b);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  logic [7:0]  s2_bytes [12] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h78, 8'h56, 8'h34, 8'h12,
                                 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [31:0] s2_words [3]  = '{32'h11223344, 32'h12345678, 32'hDEADBEEF};
  logic [7:0]  s3_bytes [10] = '{8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                 8'hA5, 8'h5A, 8'hC3, 8'h3C};
  int          s3_gaps  [10] = '{2, 0, 1, 3, 0, 2, 1, 0, 3, 1};

  initial begin
    int c0;
    int w0;
    rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; reload = 1'b0;

    // Reset values
    repeat (2) tick();
    check("rst_w_en", {28'd0, im_w_en}, 32'h0);
    check("rst_addr", {16'd0, im_address}, 32'h0);
    check("rst_wdata", im_write_data, 32'h0);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_err", {31'd0, load_err}, 32'd0);
    rst = 1'b0;
    check("rst_ready", {31'd0, byte_ready}, 32'd1);

    // 1: single word image
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("t1_w_en", {28'd0, im_w_en}, 32'hF);
    check("t1_addr", {16'd0, im_address}, 32'h0000);
    check("t1_wdata", im_write_data, 32'h00000013);
    check("t1_cpu_rst_during_write", {31'd0, cpu_rst}, 32'd1);
    tick();
    check("t1_w_en_off", {28'd0, im_w_en}, 32'h0);
    check("t1_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("t1_done", {31'd0, load_done}, 32'd1);
    check("t1_wr_cnt", wr_cnt, 32'd1);

    // 2: three words back-to-back
    do_reload();
    check("t2_reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    w0 = wr_cnt;
    c0 = cyc;
    send_byte(8'h03); send_byte(8'h00);
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) send_byte(s2_bytes[w*4+k]);
      check("t2_w_en", {28'd0, im_w_en}, 32'hF);
      check("t2_ready_low", {31'd0, byte_ready}, 32'd0);
      check("t2_addr", {16'd0, im_address}, 32'(w * 4));
      check("t2_wdata", im_write_data, s2_words[w]);
    end
    tick();
    check("t2_cycles", cyc - c0, 32'd17);
    check("t2_done", {31'd0, load_done}, 32'd1);
    check("t2_wr_cnt", wr_cnt - w0, 32'd3);

    // 3: idle gaps in header and data
    do_reload();
    w0 = wr_cnt;
    for (int i = 0; i < 10; i++) send_gap(s3_bytes[i], s3_gaps[i]);
    tick();
    check("t3_done", {31'd0, load_done}, 32'd1);
    check("t3_mem0", mem[0], 32'h04030201);
    check("t3_mem4", mem[4], 32'h3CC35AA5);
    check("t3_wr_cnt", wr_cnt - w0, 32'd2);

    // 4: N=0, N=MAX_WORDS accepted, N=MAX_WORDS+1 rejected
    do_reload();
    w0 = wr_cnt;
    send_byte(8'h00); send_byte(8'h00);
    check("t4_n0_done", {31'd0, load_done}, 32'd1);
    check("t4_n0_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("t4_n0_wr_cnt", wr_cnt - w0, 32'd0);
    do_reload();
    send_byte(8'h00); send_byte(8'h40);
    check("t4_max_err", {31'd0, load_err}, 32'd0);
    check("t4_max_ready", {31'd0, byte_ready}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    send_byte(8'h01); send_byte(8'h40);
    check("t4_err", {31'd0, load_err}, 32'd1);
    check("t4_err_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t4_err_ready", {31'd0, byte_ready}, 32'd0);
    do_reload();
    tick();
    check("t4_err_sticky", {31'd0, load_err}, 32'd1);

    // 5: reset in the middle of a word
    rst = 1'b1; tick(); rst = 1'b0;
    w0 = wr_cnt;
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    #2;
    check("t5_async_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t5_async_w_en", {28'd0, im_w_en}, 32'h0);
    check("t5_async_addr", {16'd0, im_address}, 32'h0);
    check("t5_async_done", {31'd0, load_done}, 32'd0);
    check("t5_async_err", {31'd0, load_err}, 32'd0);
    tick();
    rst = 1'b0;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hCD); send_byte(8'hAB); send_byte(8'h89);
    check("t5_addr", {16'd0, im_address}, 32'h0000);
    check("t5_wdata", im_write_data, 32'h89ABCDEF);
    tick();
    check("t5_done", {31'd0, load_done}, 32'd1);
    check("t5_wr_cnt", wr_cnt - w0, 32'd1);

    // 6: reload coinciding with a valid byte in DONE
    reload = 1'b1; byte_valid = 1'b1; byte_data = 8'h77;
    tick();
    reload = 1'b0; byte_valid = 1'b0;
    check("t6_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("t6_done_low", {31'd0, load_done}, 32'd0);
    check("t6_ready", {31'd0, byte_ready}, 32'd1);
    w0 = wr_cnt;
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    check("t6_w_en", {28'd0, im_w_en}, 32'hF);
    check("t6_addr", {16'd0, im_address}, 32'h0000);
    check("t6_wdata", im_write_data, 32'h40302010);
    tick();
    check("t6_done", {31'd0, load_done}, 32'd1);
    check("t6_wr_cnt", wr_cnt - w0, 32'd1);

    $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
    $finish;
  end

endmodule
